// File: rtl/rst_seq_ctrl.sv
// Reset release sequencer: holds all domains in reset, then releases them in index
// order, waiting (with timeout) for each domain's ready before moving to the next.
module rst_seq_ctrl #(
    parameter int NUM_DOM  = 3,
    parameter int NUM_REQ  = 2,
    parameter int HOLD_CYC = 16,
    parameter int GAP_CYC  = 5,
    parameter int TMO_CYC  = 64
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_DOM-1:0] i_dom_rdy,
    output logic [NUM_DOM-1:0] o_dom_rst,
    output logic [NUM_REQ-1:0] o_req_ack,
    output logic               o_busy,
    output logic               o_done,
    output logic [NUM_DOM-1:0] o_err
);

    localparam int CNT_MAX = (HOLD_CYC > GAP_CYC)
                           ? ((HOLD_CYC > TMO_CYC) ? HOLD_CYC : TMO_CYC)
                           : ((GAP_CYC > TMO_CYC) ? GAP_CYC : TMO_CYC);
    localparam int CW = $clog2(CNT_MAX);
    localparam int IW = $clog2(NUM_DOM);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TMO_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOM - 1);

    typedef enum logic [1:0] {S_HOLD, S_WAIT, S_GAP, S_RUN} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_DOM-1:0] dom_rst_q, dom_rst_d;
    logic [NUM_DOM-1:0] err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic new_req;
    logic step;
    logic timeout;
    logic run_entry;

    // Only requests not already pending restart an in-flight sequence.
    assign new_req   = |(i_req & ~pending_q);
    assign timeout   = (state_q == S_WAIT) && !i_dom_rdy[idx_q] && (cnt_q == TMO_LAST);
    assign step      = (state_q == S_WAIT) && (i_dom_rdy[idx_q] || (cnt_q == TMO_LAST));
    assign run_entry = step && (idx_q == IDX_LAST);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        unique case (state_q)
            S_HOLD: begin
                if (new_req) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            S_WAIT: begin
                // Reaching RUN takes priority; a coincident request is queued instead.
                if (run_entry) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else if (new_req) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (step) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end
            end
            S_GAP: begin
                if (new_req) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    idx_d   = idx_q + 1'b1;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if ((|i_req) || (|pending_q)) begin
                    state_d = S_HOLD;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = S_HOLD;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        pending_d = pending_q | i_req;
        ack_d     = '0;
        err_d     = err_q;
        if (timeout) begin
            err_d[idx_q] = 1'b1;
        end
        if (run_entry) begin
            ack_d     = pending_q;
            pending_d = i_req & ~pending_q;
        end
        busy_d = (state_d != S_RUN);
        done_d = (state_d == S_RUN);
    end

    // Domain gi is out of reset once the sequence index has reached it.
    generate
        for (genvar gi = 0; gi < NUM_DOM; gi++) begin : g_dom
            assign dom_rst_d[gi] = (state_d == S_HOLD)
                                || ((state_d != S_RUN) && (IW'(gi) > idx_d));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_rst) begin
            pending_q <= '0;
            ack_q     <= '0;
            dom_rst_q <= '1;
            err_q     <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ack_q     <= ack_d;
            dom_rst_q <= dom_rst_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_dom_rst = dom_rst_q;
    assign o_req_ack = ack_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_err     = err_q;

endmodule
